// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined 4x4 multiplier between NREQ requesters with ID-tagged responses
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_out,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_data,
  output logic              busy
);
  logic [IDW-1:0] ptr, g;
  logic           gnt;
  logic [LAT-1:0] v;
  logic [IDW-1:0] tid [LAT];
  function automatic int wrap(input int x);
    return x >= NREQ ? x - NREQ : x;
  endfunction
  always_comb begin
    req_ready = '0;
    g = '0;
    gnt = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!gnt && rst_n && !hold && req_valid[wrap(int'(ptr) + k)]) begin
        gnt = 1'b1;
        g = IDW'(wrap(int'(ptr) + k));
        req_ready[wrap(int'(ptr) + k)] = 1'b1;
      end
  end
  assign mul_a = gnt ? req_a[int'(g)*4 +: 4] : 4'd0;
  assign mul_b = gnt ? req_b[int'(g)*4 +: 4] : 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      v <= '0;
      for (int k = 0; k < LAT; k++) tid[k] <= '0;
    end else begin
      if (gnt) ptr <= int'(g) == NREQ - 1 ? '0 : g + IDW'(1);
      v[0] <= gnt;
      tid[0] <= g;
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        tid[k] <= tid[k-1];
      end
    end
  assign resp_valid = v[LAT-1];
  assign resp_id    = tid[LAT-1];
  assign resp_data  = mul_out;
  assign busy       = |v;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: randomized and directed check of mul_share_arbiter against a transaction-level model
module tb_mul_share_arbiter;
  localparam int NREQ = 4, LAT = 3, IDW = 2;
  logic clk = 0, rst_n = 0, hold = 0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [4*NREQ-1:0] req_a = '0, req_b = '0;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_out, resp_data;
  logic resp_valid, busy;
  logic [IDW-1:0] resp_id;
  logic [7:0] pipe [LAT];
  mul_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .hold(hold), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pipe[0] <= mul_a * mul_b;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_out = pipe[LAT-1];
  typedef struct {int id; int p; int due;} rsp_t;
  rsp_t q[$];
  int total = 0, bad = 0, cyc = 0, ptr = 0;
  bit pend [NREQ];
  int ra [NREQ], rb [NREQ];
  bit hold_m = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    int eg, j;
    bit bexp;
    rsp_t r;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pend[i];
      req_a[4*i +: 4] = 4'(ra[i]);
      req_b[4*i +: 4] = 4'(rb[i]);
    end
    hold = hold_m;
    #1;
    eg = -1;
    if (!hold_m)
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr + k) % NREQ;
        if (eg < 0 && pend[j]) eg = j;
      end
    chk("ready", 32'(req_ready), eg < 0 ? 0 : 1 << eg);
    chk("mul_a", 32'(mul_a), eg < 0 ? 0 : ra[eg]);
    chk("mul_b", 32'(mul_b), eg < 0 ? 0 : rb[eg]);
    bexp = q.size() != 0;
    chk("busy", 32'(busy), 32'(bexp));
    if (q.size() != 0 && q[0].due == cyc) begin
      r = q.pop_front();
      chk("rv", 32'(resp_valid), 1);
      chk("rid", 32'(resp_id), r.id);
      chk("rdata", 32'(resp_data), r.p);
    end else chk("rv", 32'(resp_valid), 0);
    @(posedge clk);
    if (eg >= 0) begin
      r.id = eg; r.p = ra[eg] * rb[eg]; r.due = cyc + LAT;
      q.push_back(r);
      ptr = (eg + 1) % NREQ;
      pend[eg] = 0;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rv", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rid", 32'(resp_id), 0);
    q.delete();
    ptr = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    cyc++;
  endtask
  task automatic req(input int i, input int a, input int b);
    pend[i] = 1; ra[i] = a; rb[i] = b;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  initial begin
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; ra[i] = 0; rb[i] = 0; end
    @(negedge clk);
    do_reset();
    req(1, 3, 5);
    idle(5);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) req(i, i + 1, 2);
      step();
    end
    idle(5);
    req(2, 7, 7);
    step();
    req(2, 6, 5); req(3, 4, 4);
    idle(6);
    req(0, 9, 9); req(1, 2, 11);
    step(); step();
    req(2, 13, 3); req(3, 5, 12);
    hold_m = 1;
    idle(5);
    hold_m = 0;
    idle(6);
    req(0, 15, 15); req(1, 0, 9); req(2, 1, 15);
    idle(6);
    for (int i = 0; i < NREQ; i++) req(i, i + 3, i + 4);
    idle(3);
    do_reset();
    idle(6);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) req(i, $urandom_range(0, 15), $urandom_range(0, 15));
        else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 0;
      hold_m = $urandom_range(0, 7) == 0;
      step();
    end
    hold_m = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    idle(LAT + 2);
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
